// File: rtl/core_pkg.sv
// Shared definitions for the RV32 front end: constants, fetch entry layout
// and a small address helper.
package core_pkg;

  // Canonical NOP (addi x0, x0, 0) presented when no instruction is valid.
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_1000;

  // One buffered fetch result: the word and the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count and a synchronous flush.
// Flush wins over push/pop in the same cycle. Pop on empty and push on
// full (without a simultaneous pop) are ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Pointers wrap explicitly so non-power-of-two depths also work.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    if (ptr == AW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + AW'(1);
    end
  endfunction

  assign empty    = (count_r == CW'(0));
  assign full     = (count_r == CW'(DEPTH));
  assign count    = count_r;
  assign pop_data = mem_r[rd_ptr_r];

  // Qualify requests against the current occupancy.
  always_comb begin
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
  end

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= next_ptr(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage of the 5-stage RV32 core. Issues word fetches on
// a valid/ready request channel, buffers in-order responses in a small FIFO
// and hands the head PC/instruction pair to decode. A branch redirect
// flushes the buffer and marks every request still in flight as stale so
// its response is dropped on arrival.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_branch_taken,
  input  logic [31:0] in_new_pc,
  input  logic        in_stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  output logic [31:0] out_PC,
  output logic [31:0] out_instruction
);

  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [31:0]   pc_r;
  logic [CW-1:0] kill_count_r;
  logic [0:0]    state_r;

  logic [0:0]    state_next_s;
  logic [CW-1:0] kill_next_s;
  logic [CW-1:0] outstanding_s;
  logic [CW-1:0] outstanding_next_s;
  logic [CW:0]   credit_used_s;
  logic          can_req_s;
  logic          req_fire_s;
  logic          resp_fire_s;
  logic          kill_active_s;
  logic          keep_resp_s;
  logic          pop_s;

  logic          ififo_full_s;
  logic          ififo_empty_s;
  logic [CW-1:0] ififo_count_s;
  fetch_entry_t  head_s;
  fetch_entry_t  push_entry_s;

  logic          pend_full_s;
  logic          pend_empty_s;
  logic [31:0]   pend_head_s;

  // Both full flags are implied by the credit rule and never needed here.
  logic          unused_full_flags_s;
  assign unused_full_flags_s = ififo_full_s ^ pend_full_s;

  // Credit, handshakes and output presentation.
  always_comb begin
    credit_used_s   = {1'b0, ififo_count_s} + {1'b0, outstanding_s};
    can_req_s       = (credit_used_s < (CW + 1)'(DEPTH));
    imem_req_valid  = reset & can_req_s & ~in_branch_taken;
    imem_req_addr   = word_align(pc_r);
    req_fire_s      = imem_req_valid & imem_req_ready;
    resp_fire_s     = imem_resp_valid & ~pend_empty_s;
    kill_active_s   = (kill_count_r != CW'(0));
    keep_resp_s     = resp_fire_s & ~kill_active_s & ~in_branch_taken;
    out_valid       = ~ififo_empty_s & ~in_branch_taken;
    pop_s           = out_valid & ~in_stall;
    push_entry_s    = '{pc: pend_head_s, instr: imem_resp_data};
    if (out_valid) begin
      out_PC          = head_s.pc;
      out_instruction = head_s.instr;
    end else begin
      out_PC          = 32'h0000_0000;
      out_instruction = NOP_INSTR;
    end
  end

  // In-flight count after this edge and the resulting stale-response count.
  always_comb begin
    outstanding_next_s = outstanding_s + CW'(req_fire_s) - CW'(resp_fire_s);
    if (in_branch_taken) begin
      kill_next_s = outstanding_next_s;
    end else if (resp_fire_s && kill_active_s) begin
      kill_next_s = kill_count_r - CW'(1);
    end else begin
      kill_next_s = kill_count_r;
    end
  end

  // RUN/DRAIN tracking: DRAIN while stale responses are still expected.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (in_branch_taken && (kill_next_s != CW'(0))) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (kill_next_s == CW'(0)) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: state_next_s = ST_RUN;
    endcase
  end

  // Fetch PC, stale-response counter and FSM state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r         <= RESET_PC;
      kill_count_r <= '0;
      state_r      <= ST_RUN;
    end else begin
      if (in_branch_taken) begin
        pc_r <= word_align(in_new_pc);
      end else if (req_fire_s) begin
        pc_r <= pc_r + 32'd4;
      end else begin
        pc_r <= pc_r;
      end
      kill_count_r <= kill_next_s;
      state_r      <= state_next_s;
    end
  end

  // Instruction buffer toward decode; flushed by a redirect.
  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_instr_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (in_branch_taken),
    .push      (keep_resp_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (ififo_full_s),
    .empty     (ififo_empty_s),
    .count     (ififo_count_s)
  );

  // Addresses of issued requests, popped as responses return. Never
  // flushed: stale responses still have to consume their entry. Its
  // occupancy is the outstanding-request count.
  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_pending_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (1'b0),
    .push      (req_fire_s),
    .push_data (imem_req_addr),
    .pop       (resp_fire_s),
    .pop_data  (pend_head_s),
    .full      (pend_full_s),
    .empty     (pend_empty_s),
    .count     (outstanding_s)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A behavioural memory returns in-order
// responses with configurable latency; the reference model tracks fetch
// epochs, the number of good instructions buffered and the next PCs that
// must be requested and delivered.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        in_branch_taken;
  logic [31:0] in_new_pc;
  logic        in_stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic [31:0] out_PC;
  logic [31:0] out_instruction;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .in_branch_taken (in_branch_taken),
    .in_new_pc       (in_new_pc),
    .in_stall        (in_stall),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_PC          (out_PC),
    .out_instruction (out_instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        memq[$];
  int          cyc;
  int          epoch;
  int          buffered;
  int          last_due;
  int          lat_lo;
  int          lat_hi;
  int          errors;
  int          checks;
  logic        last_br;
  logic [31:0] exp_req_pc;
  logic [31:0] exp_out_pc;

  // Memory contents: a simple address-dependent word.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a ^ 32'hDEAD_0000) + 32'h0000_0033;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs, advance the model.
  // br_mode: 0 = no redirect, 1 = redirect, 2 = redirect only if a
  // response arrives this cycle.
  task automatic step(input logic st, input int br_mode, input logic [31:0] npc, input logic rdy);
    logic resp_now;
    logic br;
    logic exp_rv;
    logic exp_ov;
    logic hs;
    logic popv;
    int   due;
    @(negedge clk);
    resp_now = (memq.size() > 0) && (memq[0].due <= cyc);
    br = (br_mode == 1) || ((br_mode == 2) && resp_now);
    last_br = br;
    in_stall        = st;
    in_branch_taken = br;
    in_new_pc       = npc;
    imem_req_ready  = rdy;
    imem_resp_valid = resp_now;
    imem_resp_data  = resp_now ? memf(memq[0].addr) : 32'h0000_0000;
    #1;
    exp_rv = !br && ((memq.size() + buffered) < 2);
    exp_ov = !br && (buffered > 0);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, exp_req_pc);
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      chk("out_pc", out_PC, exp_out_pc);
      chk("out_instr", out_instruction, memf(exp_out_pc));
    end else begin
      chk("nop_instr", out_instruction, 32'h0000_0013);
    end
    hs   = exp_rv && rdy;
    popv = exp_ov && !st;
    if (resp_now) begin
      if (!br && (memq[0].epoch == epoch)) buffered++;
      void'(memq.pop_front());
    end
    if (popv) begin
      buffered--;
      exp_out_pc = exp_out_pc + 32'd4;
    end
    if (hs) begin
      due = cyc + $urandom_range(lat_hi, lat_lo);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{addr: exp_req_pc, epoch: epoch, due: due});
      exp_req_pc = exp_req_pc + 32'd4;
    end
    if (br) begin
      buffered   = 0;
      epoch++;
      exp_req_pc = {npc[31:2], 2'b00};
      exp_out_pc = {npc[31:2], 2'b00};
    end
    cyc++;
  endtask

  // Assert reset (memory forgets everything), check idle outputs at once.
  task automatic do_reset(input int hold);
    @(negedge clk);
    reset           = 1'b0;
    in_branch_taken = 1'b0;
    in_stall        = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_pc", out_PC, 32'h0000_0000);
    chk("rst_out_instr", out_instruction, 32'h0000_0013);
    repeat (hold) @(negedge clk);
    reset = 1'b1;
    memq.delete();
    buffered   = 0;
    epoch++;
    last_due   = cyc;
    exp_req_pc = 32'h0000_1000;
    exp_out_pc = 32'h0000_1000;
  endtask

  initial begin
    logic st;
    logic rdy;
    int   bm;
    errors = 0; checks = 0; cyc = 0; epoch = 0; buffered = 0; last_due = 0;
    lat_lo = 1; lat_hi = 1; last_br = 1'b0;
    reset = 1'b0; in_branch_taken = 1'b0; in_new_pc = 32'h0; in_stall = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    exp_req_pc = 32'h0000_1000; exp_out_pc = 32'h0000_1000;

    do_reset(3);

    // Streaming with a single-cycle memory.
    repeat (12) step(1'b0, 0, 32'h0, 1'b1);

    // Decode stall: fetch halts on credit, head is held.
    repeat (5) step(1'b1, 0, 32'h0, 1'b1);
    repeat (4) step(1'b0, 0, 32'h0, 1'b1);

    // Redirect with two slow requests in flight.
    lat_lo = 4; lat_hi = 4;
    repeat (3) step(1'b0, 0, 32'h0, 1'b1);
    step(1'b0, 1, 32'h0000_2002, 1'b1);
    lat_lo = 1; lat_hi = 1;
    repeat (10) step(1'b0, 0, 32'h0, 1'b1);

    // Redirect in the same cycle as a response.
    lat_lo = 2; lat_hi = 2;
    repeat (4) step(1'b0, 0, 32'h0, 1'b1);
    last_br = 1'b0;
    for (int i = 0; i < 8 && !last_br; i++) step(1'b0, 2, 32'h0000_3000, 1'b1);
    chk("br_on_resp_seen", 32'(last_br), 32'h1);
    repeat (8) step(1'b0, 0, 32'h0, 1'b1);

    // Memory not ready: address held, buffer drains.
    lat_lo = 1; lat_hi = 1;
    repeat (3) step(1'b0, 0, 32'h0, 1'b0);
    repeat (4) step(1'b0, 0, 32'h0, 1'b1);

    // PC wrap past the top of the address space.
    step(1'b0, 1, 32'hFFFF_FFF9, 1'b1);
    repeat (8) step(1'b0, 0, 32'h0, 1'b1);

    // Reset mid-operation with the buffer full and requests pending.
    lat_lo = 3; lat_hi = 3;
    repeat (4) step(1'b1, 0, 32'h0, 1'b1);
    do_reset(2);
    lat_lo = 1; lat_hi = 1;
    repeat (6) step(1'b0, 0, 32'h0, 1'b1);

    // Randomised traffic.
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 600; i++) begin
      st  = ($urandom_range(99, 0) < 30);
      rdy = ($urandom_range(99, 0) < 75);
      bm  = ($urandom_range(99, 0) < 6) ? 1 : (($urandom_range(99, 0) < 4) ? 2 : 0);
      step(st, bm, $urandom, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
